// File: rtl/multi_channel_serial_transmitter_pkg.sv
// Shared types and helpers for the multi-channel serial transmitter.
// Frame geometry and baud divisor are derived from module parameters.
package multi_channel_serial_transmitter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [7:0] SYNC_DEF = 8'hA5;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int n_bytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int frame_len(input int dw, input int tw);
    return n_bytes(dw) + n_bytes(tw) + 3;
  endfunction

endpackage

// File: rtl/multi_channel_serial_transmitter_uart_tx_byte.sv
// 8N1 byte serializer; ready also rises in the last stop-bit cycle
// so a following byte starts with no idle bit in between.
module uart_tx_byte #(
  parameter int DIV = 104
) (
  input  logic       clk_12MHz,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          active;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] baud_cnt;
  logic [8:0]    sh;
  logic          baud_end;

  assign baud_end = (baud_cnt == CW'(DIV - 1));
  assign ready    = ~active | (baud_end & (bit_cnt == 4'd9));

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      tx       <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      sh       <= '1;
    end else if (start && ready) begin
      active   <= 1'b1;
      tx       <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      sh       <= {1'b1, byte_in};
    end else if (active) begin
      if (baud_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= sh[0];
          sh      <= {1'b1, sh[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_channel_serial_transmitter.sv
// N-channel sample buffer with round-robin arbiter that frames
// each captured sample into a checksummed UART packet.
module multi_channel_serial_transmitter
  import multi_channel_serial_transmitter_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter int         DATA_W    = 17,
  parameter int         TS_W      = 24,
  parameter int         CLK_HZ    = 12000000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
  parameter int         GAP_BITS  = 2
) (
  input  logic                   clk_12MHz,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        data_availible,
  input  logic [N_CH*DATA_W-1:0] decoded_data,
  input  logic [N_CH*TS_W-1:0]   timestamp_last_data,
  output logic [N_CH-1:0]        reset_decoder,
  output logic                   tx,
  output logic                   busy
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DB    = n_bytes(DATA_W);
  localparam int TB    = n_bytes(TS_W);
  localparam int L     = frame_len(DATA_W, TS_W);
  localparam int IDX_W = $clog2(L);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GAP_N = GAP_BITS * DIV;
  localparam int GW    = (GAP_N > 1) ? $clog2(GAP_N) : 1;

  logic [N_CH-1:0]   full;
  logic [N_CH-1:0]   cap;
  logic [N_CH-1:0]   clr;
  logic [DATA_W-1:0] sd [N_CH];
  logic [TS_W-1:0]   st [N_CH];

  state_t            state;
  logic [CH_W-1:0]   rr;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   gnt_q;
  logic              any;
  logic [7:0]        fb [L];
  logic [7:0]        frame [L];
  logic [IDX_W-1:0]  idx;
  logic              last;
  logic [GW-1:0]     gcnt;

  logic              start;
  logic              ready;
  logic [7:0]        byte_in;

  // Capture only looks at the registered flag, so a slot freed in
  // LOAD can refill at the earliest one cycle later.
  assign cap = data_availible & ~full;
  assign clr = (state == S_LOAD) ? (N_CH'(1) << gnt_q) : '0;

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      full          <= '0;
      reset_decoder <= '0;
    end else begin
      full          <= (full & ~clr) | cap;
      reset_decoder <= cap;
    end
  end

  always_ff @(posedge clk_12MHz) begin
    for (int i = 0; i < N_CH; i++) begin
      if (cap[i]) begin
        sd[i] <= decoded_data[i*DATA_W +: DATA_W];
        st[i] <= timestamp_last_data[i*TS_W +: TS_W];
      end
    end
  end

  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int j;
      j = int'(rr) + k;
      if (j >= N_CH) j = j - N_CH;
      if (!any && full[j]) begin
        any = 1'b1;
        gnt = CH_W'(j);
      end
    end
  end

  always_comb begin
    logic [DB*8-1:0] dp;
    logic [TB*8-1:0] tp;
    logic [7:0]      ck;
    dp    = (DB*8)'(sd[gnt_q]);
    tp    = (TB*8)'(st[gnt_q]);
    fb[0] = SYNC_BYTE;
    fb[1] = {4'(gnt_q), 4'h0};
    for (int j = 0; j < DB; j++) fb[2+j] = dp[(DB-1-j)*8 +: 8];
    for (int j = 0; j < TB; j++) fb[2+DB+j] = tp[(TB-1-j)*8 +: 8];
    ck = '0;
    for (int j = 1; j < L - 1; j++) ck = ck ^ fb[j];
    fb[L-1] = ck;
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr    <= '0;
      gnt_q <= '0;
      idx   <= '0;
      last  <= 1'b0;
      gcnt  <= '0;
      busy  <= 1'b0;
      for (int i = 0; i < L; i++) frame[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            gnt_q <= gnt;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          frame <= fb;
          rr    <= (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + 1'b1;
          idx   <= IDX_W'(1);
          last  <= 1'b0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (ready) begin
            if (last) begin
              gcnt  <= '0;
              state <= S_GAP;
            end else if (idx == IDX_W'(L - 1)) begin
              last <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP_N - 1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // SYNC goes out straight from LOAD so the start bit lands two
  // cycles after the slot fills.
  always_comb begin
    start   = (state == S_LOAD) | ((state == S_SEND) & ready & ~last);
    byte_in = (state == S_LOAD) ? SYNC_BYTE : frame[idx];
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk_12MHz(clk_12MHz),
    .rst_n    (rst_n),
    .start    (start),
    .byte_in  (byte_in),
    .ready    (ready),
    .tx       (tx)
  );

endmodule
